// File: rtl/axi_resp_generator.sv
// AXI slave response generator: answers writes with B and reads with
// address-pattern data, counting completed bursts and write errors.

package axi_resp_generator_pkg;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned USER_W = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [USER_W-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_rsp_t;

endpackage

module axi_resp_generator #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 2,
    parameter type axi_req_t = axi_resp_generator_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_resp_generator_pkg::axi_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  axi_req_t    slv_req_i,
    output axi_rsp_t    slv_rsp_o,
    output logic [31:0] wr_cnt_o,
    output logic [31:0] rd_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     en_q;

    logic [ID_WIDTH-1:0]   w_id_q, r_id_q;
    logic [7:0]            w_len_q, w_beat_q, r_len_q, r_beat_q;
    logic                  w_err_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [ADDR_WIDTH-1:0] r_addr_c;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_last_beat, r_last_beat, w_mismatch;
    logic unused_req;

    // Fields the responder does not interpret (addr/size/burst/user/data/strb)
    assign unused_req = ^slv_req_i;

    // Handshake and beat-position decode
    assign aw_hs       = slv_req_i.aw_valid && (w_state_q == W_IDLE) && en_q;
    assign w_hs        = slv_req_i.w_valid  && (w_state_q == W_DATA);
    assign b_hs        = slv_req_i.b_ready  && (w_state_q == W_RESP);
    assign ar_hs       = slv_req_i.ar_valid && (r_state_q == R_IDLE) && en_q;
    assign r_hs        = slv_req_i.r_ready  && (r_state_q == R_DATA);
    assign w_last_beat = (w_beat_q == w_len_q);
    assign r_last_beat = (r_beat_q == r_len_q);
    assign w_mismatch  = (slv_req_i.w.last != w_last_beat);
    assign r_addr_c    = r_addr_q + ADDR_WIDTH'(r_beat_q) * ADDR_WIDTH'(BEAT_BYTES);

    // State registers and post-reset enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            en_q      <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            en_q      <= 1'b1;
        end
    end

    // Next-state logic; w.last never steers the write FSM, only the beat count
    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)                w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat)  w_state_d = W_RESP;
            W_RESP:  if (b_hs)                 w_state_d = W_IDLE;
            default:                           w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE:  if (ar_hs)                r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last_beat)  r_state_d = R_IDLE;
            default:                           r_state_d = R_IDLE;
        endcase
    end

    // Write burst capture, beat count, sticky last-mismatch flag, counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            wr_cnt_o  <= '0;
            err_cnt_o <= '0;
        end else begin
            if (aw_hs) begin
                w_id_q   <= ID_WIDTH'(slv_req_i.aw.id);
                w_len_q  <= slv_req_i.aw.len;
                w_beat_q <= '0;
                w_err_q  <= 1'b0;
            end
            if (w_hs) begin
                w_beat_q <= w_beat_q + 8'd1;
                if (w_mismatch) w_err_q <= 1'b1;
            end
            if (b_hs) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
                if (w_err_q) err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

    // Read burst capture, beat advance on handshake, completion counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_q   <= '0;
            r_len_q  <= '0;
            r_beat_q <= '0;
            r_addr_q <= '0;
            rd_cnt_o <= '0;
        end else begin
            if (ar_hs) begin
                r_id_q   <= ID_WIDTH'(slv_req_i.ar.id);
                r_len_q  <= slv_req_i.ar.len;
                r_addr_q <= ADDR_WIDTH'(slv_req_i.ar.addr);
                r_beat_q <= '0;
            end
            if (r_hs) begin
                if (r_last_beat) rd_cnt_o <= rd_cnt_o + 32'd1;
                else             r_beat_q <= r_beat_q + 8'd1;
            end
        end
    end

    // Response channel decode from registered state only
    always_comb begin
        slv_rsp_o          = '0;
        slv_rsp_o.aw_ready = (w_state_q == W_IDLE) && en_q;
        slv_rsp_o.w_ready  = (w_state_q == W_DATA);
        slv_rsp_o.b_valid  = (w_state_q == W_RESP);
        slv_rsp_o.b.id     = w_id_q;
        slv_rsp_o.b.resp   = w_err_q ? 2'b10 : 2'b00;
        slv_rsp_o.b.user   = USER_WIDTH'(0);
        slv_rsp_o.ar_ready = (r_state_q == R_IDLE) && en_q;
        slv_rsp_o.r_valid  = (r_state_q == R_DATA);
        slv_rsp_o.r.id     = r_id_q;
        slv_rsp_o.r.data   = DATA_WIDTH'(r_addr_c);
        slv_rsp_o.r.resp   = 2'b00;
        slv_rsp_o.r.last   = r_last_beat;
        slv_rsp_o.r.user   = USER_WIDTH'(0);
    end

endmodule

// File: tb/tb_axi_resp_generator.sv
// Directed bench for axi_resp_generator: vector table plus corner sequences.

module tb_axi_resp_generator;

    import axi_resp_generator_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic [31:0] wr_cnt, rd_cnt;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    axi_resp_generator dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .slv_req_i (req),
        .slv_rsp_o (rsp),
        .wr_cnt_o  (wr_cnt),
        .rd_cnt_o  (rd_cnt),
        .err_cnt_o (err_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic aw_v; logic [7:0] aw_id; logic [7:0] aw_len;
        logic w_v; logic w_last; logic b_rdy;
        logic ar_v; logic [7:0] ar_id; logic [63:0] ar_addr; logic [7:0] ar_len; logic r_rdy;
        logic x_awr; logic x_wrdy; logic x_bv; logic [7:0] x_bid; logic [1:0] x_bresp;
        logic x_arr; logic x_rv; logic x_rlast; logic [7:0] x_rid; logic [63:0] x_rdata;
        logic [31:0] x_wrc; logic [31:0] x_rdc; logic [15:0] x_errc;
    } vec_t;

    localparam int NV = 26;
    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        req = '0;
    endtask

    initial begin
        logic pat [9];
        int   beat;
        int   n;
        logic done;

        // in: aw_v id len | w_v last | b_rdy | ar_v id addr len | r_rdy
        // exp: awr wrdy bv bid bresp | arr rv rlast rid rdata | wr rd err
        vt[0]  = '{L1,8'd3,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd0,32'd0,16'd0};
        vt[1]  = '{L0,8'd0,8'd0, L1,L1, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd0,32'd0,16'd0};
        vt[2]  = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L0,L1,8'd3,2'd0, L1,L0,L0,8'd0,64'h0, 32'd0,32'd0,16'd0};
        vt[3]  = '{L0,8'd0,8'd0, L0,L0, L1, L0,8'd0,64'h0,8'd0, L0,  L0,L0,L1,8'd3,2'd0, L1,L0,L0,8'd0,64'h0, 32'd0,32'd0,16'd0};
        vt[4]  = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd1,32'd0,16'd0};
        vt[5]  = '{L1,8'd7,8'd1, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd1,32'd0,16'd0};
        vt[6]  = '{L0,8'd0,8'd0, L1,L1, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd1,32'd0,16'd0};
        vt[7]  = '{L0,8'd0,8'd0, L1,L1, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd1,32'd0,16'd0};
        vt[8]  = '{L0,8'd0,8'd0, L0,L0, L1, L0,8'd0,64'h0,8'd0, L0,  L0,L0,L1,8'd7,2'd2, L1,L0,L0,8'd0,64'h0, 32'd1,32'd0,16'd0};
        vt[9]  = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd2,32'd0,16'd1};
        vt[10] = '{L1,8'd1,8'd1, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd2,32'd0,16'd1};
        vt[11] = '{L0,8'd0,8'd0, L1,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd2,32'd0,16'd1};
        vt[12] = '{L0,8'd0,8'd0, L1,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd2,32'd0,16'd1};
        vt[13] = '{L0,8'd0,8'd0, L0,L0, L1, L0,8'd0,64'h0,8'd0, L0,  L0,L0,L1,8'd1,2'd2, L1,L0,L0,8'd0,64'h0, 32'd2,32'd0,16'd1};
        vt[14] = '{L1,8'd2,8'd1, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd3,32'd0,16'd2};
        vt[15] = '{L0,8'd0,8'd0, L1,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd3,32'd0,16'd2};
        vt[16] = '{L0,8'd0,8'd0, L1,L1, L0, L0,8'd0,64'h0,8'd0, L0,  L0,L1,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd3,32'd0,16'd2};
        vt[17] = '{L0,8'd0,8'd0, L0,L0, L1, L0,8'd0,64'h0,8'd0, L0,  L0,L0,L1,8'd2,2'd0, L1,L0,L0,8'd0,64'h0, 32'd3,32'd0,16'd2};
        vt[18] = '{L0,8'd0,8'd0, L0,L0, L0, L1,8'd5,64'h1000,8'd3, L1, L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd4,32'd0,16'd2};
        vt[19] = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L1,  L1,L0,L0,8'd0,2'd0, L0,L1,L0,8'd5,64'h1000, 32'd4,32'd0,16'd2};
        vt[20] = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L1,  L1,L0,L0,8'd0,2'd0, L0,L1,L0,8'd5,64'h1008, 32'd4,32'd0,16'd2};
        vt[21] = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L1,  L1,L0,L0,8'd0,2'd0, L0,L1,L0,8'd5,64'h1010, 32'd4,32'd0,16'd2};
        vt[22] = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L1,  L1,L0,L0,8'd0,2'd0, L0,L1,L1,8'd5,64'h1018, 32'd4,32'd0,16'd2};
        vt[23] = '{L0,8'd0,8'd0, L0,L0, L0, L1,8'd9,64'h20,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd4,32'd1,16'd2};
        vt[24] = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L1,  L1,L0,L0,8'd0,2'd0, L0,L1,L1,8'd9,64'h20, 32'd4,32'd1,16'd2};
        vt[25] = '{L0,8'd0,8'd0, L0,L0, L0, L0,8'd0,64'h0,8'd0, L0,  L1,L0,L0,8'd0,2'd0, L1,L0,L0,8'd0,64'h0, 32'd4,32'd2,16'd2};

        // Reset state and post-release enable delay
        rst_ni = 1'b0;
        clr_in();
        @(negedge clk_i); #1;
        chk("rst aw_ready", 64'(rsp.aw_ready), 64'd0);
        chk("rst ar_ready", 64'(rsp.ar_ready), 64'd0);
        chk("rst w_ready",  64'(rsp.w_ready),  64'd0);
        chk("rst b_valid",  64'(rsp.b_valid),  64'd0);
        chk("rst r_valid",  64'(rsp.r_valid),  64'd0);
        chk("rst wr_cnt",   64'(wr_cnt),       64'd0);
        chk("rst rd_cnt",   64'(rd_cnt),       64'd0);
        chk("rst err_cnt",  64'(err_cnt),      64'd0);
        @(negedge clk_i); #2;
        rst_ni = 1'b1;
        #1;
        chk("release aw_ready", 64'(rsp.aw_ready), 64'd0);
        chk("release ar_ready", 64'(rsp.ar_ready), 64'd0);

        // Table-driven vectors: drive, then check pre-edge outputs
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            req.aw_valid = vt[i].aw_v;
            req.aw.id    = vt[i].aw_id;
            req.aw.len   = vt[i].aw_len;
            req.w_valid  = vt[i].w_v;
            req.w.last   = vt[i].w_last;
            req.b_ready  = vt[i].b_rdy;
            req.ar_valid = vt[i].ar_v;
            req.ar.id    = vt[i].ar_id;
            req.ar.addr  = vt[i].ar_addr;
            req.ar.len   = vt[i].ar_len;
            req.r_ready  = vt[i].r_rdy;
            #1;
            chk($sformatf("v%0d aw_ready", i), 64'(rsp.aw_ready), 64'(vt[i].x_awr));
            chk($sformatf("v%0d w_ready", i),  64'(rsp.w_ready),  64'(vt[i].x_wrdy));
            chk($sformatf("v%0d b_valid", i),  64'(rsp.b_valid),  64'(vt[i].x_bv));
            chk($sformatf("v%0d ar_ready", i), 64'(rsp.ar_ready), 64'(vt[i].x_arr));
            chk($sformatf("v%0d r_valid", i),  64'(rsp.r_valid),  64'(vt[i].x_rv));
            chk($sformatf("v%0d wr_cnt", i),   64'(wr_cnt),       64'(vt[i].x_wrc));
            chk($sformatf("v%0d rd_cnt", i),   64'(rd_cnt),       64'(vt[i].x_rdc));
            chk($sformatf("v%0d err_cnt", i),  64'(err_cnt),      64'(vt[i].x_errc));
            if (vt[i].x_bv) begin
                chk($sformatf("v%0d b_id", i),   64'(rsp.b.id),   64'(vt[i].x_bid));
                chk($sformatf("v%0d b_resp", i), 64'(rsp.b.resp), 64'(vt[i].x_bresp));
            end
            if (vt[i].x_rv) begin
                chk($sformatf("v%0d r_data", i), 64'(rsp.r.data), vt[i].x_rdata);
                chk($sformatf("v%0d r_last", i), 64'(rsp.r.last), 64'(vt[i].x_rlast));
                chk($sformatf("v%0d r_id", i),   64'(rsp.r.id),   64'(vt[i].x_rid));
            end
        end

        // Read back-pressure: fields hold across stalls, no lost/duplicate beats
        @(negedge clk_i);
        clr_in();
        req.ar_valid = 1'b1; req.ar.id = 8'd5; req.ar.addr = 64'h1000; req.ar.len = 8'd3;
        #1;
        chk("bp ar_ready", 64'(rsp.ar_ready), 64'd1);
        pat  = '{L1, L0, L0, L1, L1, L0, L1, L1, L1};
        beat = 0;
        for (int c = 0; c < 9 && beat < 4; c++) begin
            @(negedge clk_i);
            req.ar_valid = 1'b0;
            req.r_ready  = pat[c];
            #1;
            chk($sformatf("bp c%0d r_valid", c), 64'(rsp.r_valid), 64'd1);
            chk($sformatf("bp c%0d r_data", c),  64'(rsp.r.data),  64'h1000 + 64'(beat * 8));
            chk($sformatf("bp c%0d r_last", c),  64'(rsp.r.last),  64'(beat == 3));
            chk($sformatf("bp c%0d r_id", c),    64'(rsp.r.id),    64'd5);
            if (pat[c]) beat++;
        end
        chk("bp beats done", 64'(beat), 64'd4);
        @(negedge clk_i);
        clr_in();
        #1;
        chk("bp r_valid idle", 64'(rsp.r_valid), 64'd0);
        chk("bp rd_cnt",       64'(rd_cnt),      64'd3);

        // Read during write W_DATA phase, then W before AW
        @(negedge clk_i);
        req.aw_valid = 1'b1; req.aw.id = 8'd4; req.aw.len = 8'd2;
        #1;
        chk("cc aw_ready", 64'(rsp.aw_ready), 64'd1);
        @(negedge clk_i);
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b1; req.ar.id = 8'd6; req.ar.addr = 64'h300; req.ar.len = 8'd1;
        req.r_ready  = 1'b1;
        #1;
        chk("cc w_ready wdata", 64'(rsp.w_ready),  64'd1);
        chk("cc ar_ready",      64'(rsp.ar_ready), 64'd1);
        @(negedge clk_i);
        req.ar_valid = 1'b0;
        #1;
        chk("cc r0 data",   64'(rsp.r.data),   64'h300);
        chk("cc r0 last",   64'(rsp.r.last),   64'd0);
        chk("cc ar_ready busy", 64'(rsp.ar_ready), 64'd0);
        @(negedge clk_i); #1;
        chk("cc r1 data",   64'(rsp.r.data), 64'h308);
        chk("cc r1 last",   64'(rsp.r.last), 64'd1);
        @(negedge clk_i); #1;
        chk("cc r_valid done", 64'(rsp.r_valid), 64'd0);
        chk("cc rd_cnt",       64'(rd_cnt),      64'd4);
        chk("cc w_ready held", 64'(rsp.w_ready), 64'd1);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk_i);
            req.w_valid = 1'b1; req.w.last = (b == 2);
            #1;
            chk($sformatf("cc w%0d w_ready", b), 64'(rsp.w_ready), 64'd1);
        end
        @(negedge clk_i);
        req.w_valid = 1'b0; req.w.last = 1'b0;
        req.aw_valid = 1'b1; req.aw.id = 8'd8; req.aw.len = 8'd0;
        #1;
        chk("cc b_valid",       64'(rsp.b_valid),  64'd1);
        chk("cc b_id",          64'(rsp.b.id),     64'd4);
        chk("cc b_resp",        64'(rsp.b.resp),   64'd0);
        chk("cc aw_ready wresp", 64'(rsp.aw_ready), 64'd0);
        @(negedge clk_i);
        req.b_ready = 1'b1;
        #1;
        chk("cc b stable",      64'(rsp.b_valid),  64'd1);
        chk("cc aw_ready wresp2", 64'(rsp.aw_ready), 64'd0);
        @(negedge clk_i);
        req.aw_valid = 1'b0; req.b_ready = 1'b0;
        req.w_valid  = 1'b1; req.w.last = 1'b1;
        #1;
        chk("cc early w aw_ready", 64'(rsp.aw_ready), 64'd1);
        chk("cc early w w_ready",  64'(rsp.w_ready),  64'd0);
        chk("cc wr_cnt",           64'(wr_cnt),       64'd5);
        @(negedge clk_i); #1;
        chk("cc early w w_ready2", 64'(rsp.w_ready), 64'd0);
        @(negedge clk_i);
        req.aw_valid = 1'b1;
        #1;
        chk("cc aw accept", 64'(rsp.aw_ready), 64'd1);
        chk("cc w_ready pre-aw", 64'(rsp.w_ready), 64'd0);
        @(negedge clk_i);
        req.aw_valid = 1'b0;
        #1;
        chk("cc w_ready post-aw", 64'(rsp.w_ready), 64'd1);
        @(negedge clk_i);
        req.w_valid = 1'b0; req.b_ready = 1'b1;
        #1;
        chk("cc b2 valid", 64'(rsp.b_valid), 64'd1);
        chk("cc b2 id",    64'(rsp.b.id),    64'd8);
        chk("cc b2 resp",  64'(rsp.b.resp),  64'd0);
        @(negedge clk_i);
        clr_in();
        #1;
        chk("cc wr_cnt2",  64'(wr_cnt),  64'd6);
        chk("cc err_cnt2", 64'(err_cnt), 64'd2);

        // Maximum length read: 256 beats
        @(negedge clk_i);
        req.ar_valid = 1'b1; req.ar.id = 8'd1; req.ar.addr = 64'h0; req.ar.len = 8'd255;
        req.r_ready  = 1'b1;
        #1;
        chk("long ar_ready", 64'(rsp.ar_ready), 64'd1);
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk_i);
            req.ar_valid = 1'b0;
            #1;
            if (rsp.r_valid) begin
                chk($sformatf("long beat%0d data", n), 64'(rsp.r.data), 64'(n * 8));
                if (rsp.r.last) done = 1'b1;
                n++;
            end
        end
        chk("long beat count", 64'(n), 64'd256);
        @(negedge clk_i);
        clr_in();
        #1;
        chk("long rd_cnt", 64'(rd_cnt), 64'd5);

        // Reset during beat 2 of a len=7 read
        @(negedge clk_i);
        req.ar_valid = 1'b1; req.ar.id = 8'hA; req.ar.addr = 64'h2000; req.ar.len = 8'd7;
        req.r_ready  = 1'b1;
        #1;
        chk("rr ar_ready", 64'(rsp.ar_ready), 64'd1);
        @(negedge clk_i);
        req.ar_valid = 1'b0;
        #1;
        chk("rr beat0", 64'(rsp.r.data), 64'h2000);
        @(negedge clk_i); #1;
        chk("rr beat1", 64'(rsp.r.data), 64'h2008);
        @(negedge clk_i); #1;
        chk("rr beat2", 64'(rsp.r.data), 64'h2010);
        #1;
        rst_ni = 1'b0;
        clr_in();
        #1;
        chk("rr r_valid async", 64'(rsp.r_valid),  64'd0);
        chk("rr ar_ready rst",  64'(rsp.ar_ready), 64'd0);
        chk("rr aw_ready rst",  64'(rsp.aw_ready), 64'd0);
        chk("rr wr_cnt",        64'(wr_cnt),       64'd0);
        chk("rr rd_cnt",        64'(rd_cnt),       64'd0);
        chk("rr err_cnt",       64'(err_cnt),      64'd0);
        @(negedge clk_i); #1;
        chk("rr r_valid held", 64'(rsp.r_valid), 64'd0);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("rr ar_ready release", 64'(rsp.ar_ready), 64'd0);
        @(negedge clk_i); #1;
        chk("rr ar_ready enabled", 64'(rsp.ar_ready), 64'd1);
        chk("rr r_valid after",    64'(rsp.r_valid),  64'd0);
        chk("rr b_valid after",    64'(rsp.b_valid),  64'd0);
        chk("rr rd_cnt after",     64'(rd_cnt),       64'd0);
        @(negedge clk_i); #1;
        chk("rr r_valid later", 64'(rsp.r_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
